// File: rtl/sprite_cmd_sequencer_if.sv
// Avalon-MM register bus between the host and the sprite command sequencer.
interface sprite_cmd_sequencer_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave  (input chipselect, write, read, address, writedata, output readdata);
  modport master (output chipselect, write, read, address, writedata, input readdata);
endinterface

// File: rtl/sprite_cmd_sequencer.sv
// Command FIFO that replays sprite words to the display bus and issues the buffer
// flush at vertical blank. Define SEQ_AUTO_PP_EN to let the sequencer own pp_selc.
module sprite_cmd_sequencer #(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [9:0] VBLANK_LINE = 10'd480
) (
  input  logic                         clk,
  input  logic                         reset,
  sprite_cmd_sequencer_if.slave        avs,
  input  logic [9:0]                   vcount,
  output logic [31:0]                  cmd_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_WAIT, S_FLUSH} state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, bnd_q, bnd_d;
  logic          front_q, front_d, ovf_q, ovf_d, corun_q, corun_d;
  logic [31:0]   cmd_q, cmd_d;
  logic          push_req, push_ok, commit_req, stat_rd, pop;
  logic [31:0]   head, pop_word, flush_word;
  logic          flush_pp, front_at_flush;

  assign push_req   = avs.chipselect & avs.write & (avs.address == 2'd0);
  assign commit_req = avs.chipselect & avs.write & (avs.address == 2'd1);
  assign stat_rd    = avs.chipselect & avs.read  & (avs.address == 2'd2);
  // Fullness is judged on the start-of-cycle count, so a same-cycle pop never admits a push.
  assign push_ok    = push_req & (count_q < DEPTH_C);
  assign pop        = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

`ifdef SEQ_AUTO_PP_EN
  logic back;
  assign back           = ~front_q;
  assign pop_word       = {head[31:14], back, head[12:0]};
  assign flush_pp       = back;
  assign front_at_flush = back;
`else
  logic pp_cap_q, pp_cap_d;
  assign pop_word       = head;
  assign flush_pp       = pp_cap_q;
  assign front_at_flush = pp_cap_q;

  always_comb begin
    pp_cap_d = pp_cap_q;
    if (commit_req && (state_q == S_RUN)) pp_cap_d = avs.writedata[13];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pp_cap_q <= 1'b0;
    else        pp_cap_q <= pp_cap_d;
  end
`endif

  assign flush_word   = {11'b0, 4'b1111, 3'b0, flush_pp, 13'b0};
  assign avs.readdata = stat_rd ? {16'b0, 9'(count_q), 4'b0, corun_q, ovf_q, front_q} : 32'h0;
  assign cmd_out      = cmd_q;

  always_comb begin
    state_d  = state_q;
    bnd_d    = bnd_q;
    front_d  = front_q;
    cmd_d    = 32'h0;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    ovf_d    = ovf_q & ~stat_rd;
    corun_d  = corun_q & ~stat_rd;
    if (push_req && !push_ok) ovf_d = 1'b1;
    if (commit_req && (state_q != S_RUN)) corun_d = 1'b1;
    if (pop) cmd_d = pop_word;
    case (state_q)
      S_RUN: begin
        // The frame boundary includes this cycle's push and pop.
        if (commit_req) begin
          bnd_d   = count_d;
          state_d = (count_d != '0) ? S_DRAIN : S_WAIT;
        end
      end
      S_DRAIN: begin
        if (pop) begin
          bnd_d = bnd_q - CW'(1);
          if (bnd_q == CW'(1)) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (vcount >= VBLANK_LINE) begin
          state_d = S_FLUSH;
          cmd_d   = flush_word;
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
        front_d = front_at_flush;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= avs.writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bnd_q    <= '0;
      front_q  <= 1'b0;
      ovf_q    <= 1'b0;
      corun_q  <= 1'b0;
      cmd_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bnd_q    <= bnd_d;
      front_q  <= front_d;
      ovf_q    <= ovf_d;
      corun_q  <= corun_d;
      cmd_q    <= cmd_d;
    end
  end
endmodule
